// File: rtl/turfio_sync_issuer.sv
// turfio_sync_issuer: TURFIO-side sync controller. Runs the local 16-cycle
// ifclk phase counter and issues a SYNC to the command encoder on a phase
// boundary. After the programmed delay it restarts the local phase. It then
// times the round trip of the SURF's returned sync and watches it for slips.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for sync_go_i; slip monitor active once locked
// ALIGN   | waiting for local phase 15 so the command lands on phase 0
// ISSUE   | SYNC requested at the encoder, waiting for cmd_ack_i
// DELAY   | counting sync_delay_i before restarting the local phase
// MEASURE | timing the round trip to the first returned SURF sync
// CHECK   | confirming the next returned sync lands on the locked phase
module turfio_sync_issuer #(
    parameter int unsigned MEAS_TIMEOUT = 255
) (
    input  logic       ifclk_i,
    input  logic       rstn_i,
    input  logic       sync_go_i,
    input  logic [4:0] sync_delay_i,
    output logic       cmd_sync_o,
    input  logic       cmd_ack_i,
    input  logic       surf_sync_i,
    output logic [3:0] phase_o,
    output logic       sync_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] latency_o,
    output logic       timeout_o,
    output logic       phase_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ISSUE,
        S_DELAY,
        S_MEASURE,
        S_CHECK
    } state_t;

    // Last latency count at which MEASURE may still capture; the timeout
    // flag then becomes visible MEAS_TIMEOUT+1 cycles after the ack cycle.
    localparam logic [7:0] TMO_LAST = 8'(MEAS_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic       sync_q;
    logic       busy_q;
    logic       cmd_q, cmd_d;
    logic       done_q, done_d;
    logic [4:0] dly_q, dly_d;
    logic [7:0] lat_cnt_q, lat_cnt_d;
    logic [7:0] lat_inc;
    logic [7:0] latency_q, latency_d;
    logic [3:0] lock_phase_q, lock_phase_d;
    logic       lock_q, lock_d;
    logic [4:0] chk_q, chk_d;
    logic       timeout_q, timeout_d;
    logic       perr_q, perr_d;

    // Saturating increment of the round-trip latency counter
    always_comb begin
        lat_inc = (lat_cnt_q == 8'hFF) ? lat_cnt_q : lat_cnt_q + 8'd1;
    end

    // Sequencing, phase counter next value and sticky status flags
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + 4'd1;
        cmd_d        = cmd_q;
        done_d       = 1'b0;
        dly_d        = dly_q;
        lat_cnt_d    = lat_cnt_q;
        latency_d    = latency_q;
        lock_phase_d = lock_phase_q;
        lock_d       = lock_q;
        chk_d        = chk_q;
        timeout_d    = timeout_q;
        perr_d       = perr_q;

        if (lock_q && surf_sync_i && (phase_q != lock_phase_q)) begin
            perr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sync_go_i) begin
                    state_d   = S_ALIGN;
                    timeout_d = 1'b0;
                    perr_d    = 1'b0;
                    lock_d    = 1'b0;
                end
            end
            S_ALIGN: begin
                if (phase_q == 4'd15) begin
                    state_d = S_ISSUE;
                    cmd_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                // A returned sync in the ack cycle is stale and falls through here.
                if (cmd_ack_i) begin
                    state_d   = S_DELAY;
                    cmd_d     = 1'b0;
                    dly_d     = '0;
                    lat_cnt_d = '0;
                end
            end
            S_DELAY: begin
                lat_cnt_d = lat_inc;
                dly_d     = dly_q + 5'd1;
                if (dly_q == sync_delay_i) begin
                    phase_d = '0;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                lat_cnt_d = lat_inc;
                if (surf_sync_i) begin
                    latency_d    = lat_cnt_q;
                    lock_phase_d = phase_q;
                    chk_d        = 5'd16;
                    state_d      = S_CHECK;
                end else if (lat_cnt_q >= TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_CHECK: begin
                // chk_q is a down-counter: 17 cycles allowed for the next pulse.
                if (surf_sync_i) begin
                    if (phase_q == lock_phase_q) begin
                        done_d = 1'b1;
                        lock_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (chk_q == 5'd0) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    chk_d = chk_q - 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cmd_d   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge ifclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            sync_q       <= 1'b0;
            busy_q       <= 1'b0;
            cmd_q        <= 1'b0;
            done_q       <= 1'b0;
            dly_q        <= '0;
            lat_cnt_q    <= '0;
            latency_q    <= '0;
            lock_phase_q <= '0;
            lock_q       <= 1'b0;
            chk_q        <= '0;
            timeout_q    <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            sync_q       <= (phase_d == 4'd15);
            busy_q       <= (state_d != S_IDLE);
            cmd_q        <= cmd_d;
            done_q       <= done_d;
            dly_q        <= dly_d;
            lat_cnt_q    <= lat_cnt_d;
            latency_q    <= latency_d;
            lock_phase_q <= lock_phase_d;
            lock_q       <= lock_d;
            chk_q        <= chk_d;
            timeout_q    <= timeout_d;
            perr_q       <= perr_d;
        end
    end

    assign cmd_sync_o  = cmd_q;
    assign phase_o     = phase_q;
    assign sync_o      = sync_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign latency_o   = latency_q;
    assign timeout_o   = timeout_q;
    assign phase_err_o = perr_q;

endmodule

// File: tb/tb_turfio_sync_issuer.sv
// Testbench for turfio_sync_issuer: vector table of full sync sequences with
// a cycle-stamped scoreboard, plus hand-written reset, slip and timeout cases.
module tb_turfio_sync_issuer;

    localparam int MT = 255;
    localparam int K_PH = 0, K_CMD = 1, K_LAT = 2, K_DONE = 3, K_BUSY = 4, K_TMO = 5, K_PERR = 6;

    logic       ifclk_i      = 1'b0;
    logic       rstn_i       = 1'b0;
    logic       sync_go_i    = 1'b0;
    logic [4:0] sync_delay_i = 5'd0;
    logic       cmd_ack_i    = 1'b0;
    logic       surf_sync_i  = 1'b0;
    logic       cmd_sync_o;
    logic [3:0] phase_o;
    logic       sync_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] latency_o;
    logic       timeout_o;
    logic       phase_err_o;

    turfio_sync_issuer #(.MEAS_TIMEOUT(MT)) dut (
        .ifclk_i      (ifclk_i),
        .rstn_i       (rstn_i),
        .sync_go_i    (sync_go_i),
        .sync_delay_i (sync_delay_i),
        .cmd_sync_o   (cmd_sync_o),
        .cmd_ack_i    (cmd_ack_i),
        .surf_sync_i  (surf_sync_i),
        .phase_o      (phase_o),
        .sync_o       (sync_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .latency_o    (latency_o),
        .timeout_o    (timeout_o),
        .phase_err_o  (phase_err_o)
    );

    always #5 ifclk_i = ~ifclk_i;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    typedef struct {
        int dly;
        int ack_lag;
        int first;
        int cap;
        int lat;
        bit busy_go;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[5];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   cyc       = 0;
    int   done_seen = 0;
    int   surf_next = 0;
    int   last_lat  = 0;
    bit   surf_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int get_out(input int kind);
        case (kind)
            K_PH:    return int'(phase_o);
            K_CMD:   return int'(cmd_sync_o);
            K_LAT:   return int'(latency_o);
            K_DONE:  return int'(done_o);
            K_BUSY:  return int'(busy_o);
            K_TMO:   return int'(timeout_o);
            K_PERR:  return int'(phase_err_o);
            default: return -1;
        endcase
    endfunction

    task automatic push(input string name, input int c, input int kind, input int val);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    // One clock: sample 1 ns after the edge, retire due expectations, drive the SURF model.
    task automatic step();
        @(posedge ifclk_i);
        #1;
        cyc++;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                check(sbq[i].name, get_out(sbq[i].kind), sbq[i].val);
                sbq.delete(i);
            end
        end
        if (done_o) done_seen++;
        surf_sync_i = surf_en && (cyc == surf_next);
        if (surf_sync_i) surf_next += 16;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_phase"}, phase_o, 0);
        check({tag, "_sync"}, sync_o, 0);
        check({tag, "_cmd"}, cmd_sync_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_lat"}, latency_o, 0);
        check({tag, "_tmo"}, timeout_o, 0);
        check({tag, "_perr"}, phase_err_o, 0);
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while (phase_o != 4'(ph) && n < 20) begin
            step();
            n++;
        end
        check("wait_phase", phase_o, ph);
    endtask

    // Request a sync at phase 3 and run up to the cycle in which the ack is driven.
    task automatic issue_to_ack(input bit busy_go, input int ack_lag, output int a_cyc);
        int g;
        wait_phase(3);
        sync_go_i = 1'b1;
        g = cyc;
        push("align_cmd_low", g + 12, K_CMD, 0);
        push("issue_cmd_high", g + 13, K_CMD, 1);
        push("issue_phase0", g + 13, K_PH, 0);
        step();
        sync_go_i = 1'b0;
        check("go_busy", busy_o, 1);
        check("go_clr_tmo", timeout_o, 0);
        check("go_clr_perr", phase_err_o, 0);
        while (cyc < g + 13) step();
        for (int k = 0; k < ack_lag; k++) begin
            if (busy_go && k == 0) begin
                sync_go_i = 1'b1;
                push("busy_go_ignored", cyc + 1, K_CMD, 1);
            end
            step();
            sync_go_i = 1'b0;
        end
        a_cyc = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        int c;
        surf_en     = 1'b0;
        surf_sync_i = 1'b0;
        sync_delay_i = 5'(v.dly);
        issue_to_ack(v.busy_go, v.ack_lag, a);
        c = a + v.cap;
        cmd_ack_i = 1'b1;
        if (v.first == 0) begin
            surf_sync_i = 1'b1;
            surf_next   = a + 16;
        end else begin
            surf_next = a + v.first;
        end
        surf_en = 1'b1;
        push("ack_cmd_drop", a + 1, K_CMD, 0);
        push("restart_phase0", a + v.dly + 2, K_PH, 0);
        push("restart_phase1", a + v.dly + 3, K_PH, 1);
        push("latency", c + 1, K_LAT, v.lat);
        push("done_early", c + 16, K_DONE, 0);
        push("busy_in_check", c + 16, K_BUSY, 1);
        push("done_pulse", c + 17, K_DONE, 1);
        push("busy_drop", c + 17, K_BUSY, 0);
        push("done_single", c + 18, K_DONE, 0);
        done_seen = 0;
        step();
        cmd_ack_i = 1'b0;
        while (cyc < c + 20) step();
        check("done_count", done_seen, 1);
        check("seq_tmo", timeout_o, 0);
        check("seq_perr", phase_err_o, 0);
        last_lat = v.lat;
    endtask

    // Locked and pulses running: push one returned pulse a cycle late.
    task automatic slip_test();
        int p;
        p = surf_next;
        surf_next = p + 1;
        push("slip_pre", p + 1, K_PERR, 0);
        push("slip_err", p + 2, K_PERR, 1);
        push("slip_sticky", p + 20, K_PERR, 1);
        while (cyc < p + 1) step();
        surf_next = p + 16;
        while (cyc < p + 20) step();
    endtask

    task automatic timeout_test();
        int a;
        surf_en      = 1'b0;
        surf_sync_i  = 1'b0;
        sync_delay_i = 5'd4;
        issue_to_ack(1'b0, 1, a);
        cmd_ack_i = 1'b1;
        push("tmo_before", a + MT, K_TMO, 0);
        push("tmo_busy_before", a + MT, K_BUSY, 1);
        push("tmo_set", a + MT + 1, K_TMO, 1);
        push("tmo_busy_drop", a + MT + 1, K_BUSY, 0);
        done_seen = 0;
        step();
        cmd_ack_i = 1'b0;
        while (cyc < a + MT + 4) step();
        check("tmo_no_done", done_seen, 0);
        check("tmo_sticky", timeout_o, 1);
        check("tmo_lat_hold", latency_o, last_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        vecs[0] = '{dly: 5,  ack_lag: 2, first: 40,  cap: 40,  lat: 39, busy_go: 1'b0};
        vecs[1] = '{dly: 0,  ack_lag: 0, first: 2,   cap: 2,   lat: 1,  busy_go: 1'b0};
        vecs[2] = '{dly: 31, ack_lag: 1, first: 33,  cap: 33,  lat: 32, busy_go: 1'b0};
        vecs[3] = '{dly: 3,  ack_lag: 2, first: 0,   cap: 16,  lat: 15, busy_go: 1'b1};
        vecs[4] = '{dly: 10, ack_lag: 3, first: 100, cap: 100, lat: 99, busy_go: 1'b0};

        step();
        step();
        check_zero("rst_init");
        rstn_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            check("free_phase", phase_o, k % 16);
            check("free_sync", sync_o, (k % 16 == 15) ? 1 : 0);
        end
        #3 rstn_i = 1'b0;
        #1 check_zero("rst_async");
        step();
        check_zero("rst_held");
        rstn_i = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            if (i == 0) slip_test();
            if (i == 1) timeout_test();
        end

        surf_en     = 1'b0;
        surf_sync_i = 1'b0;
        issue_to_ack(1'b0, 0, a);
        check("pre_rst_cmd", cmd_sync_o, 1);
        #2 rstn_i = 1'b0;
        #1 check_zero("rst_issue");
        #2 rstn_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_busy", busy_o, 0);
            check("post_rst_cmd", cmd_sync_o, 0);
        end
        check("scoreboard_drain", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/turfio_sync_issuer.md
# turfio_sync_issuer

Controller-side counterpart of the SURF sync generator. It runs the TURFIO's free-running 16-cycle ifclk phase counter and issues a SYNC command to the command encoder on request, aligned to a phase boundary. It applies the programmed sync delay to its own counter so that both ends restart together. It then measures the round-trip latency of the SURF's returned sync pulse (recovered from COUT) and monitors that pulse for phase slips.

## Interface
Parameters:
- MEAS_TIMEOUT, 255: maximum ifclk cycles waited for the returned SURF sync before declaring timeout (≤255).

Ports:
- ifclk_i  in  1  interface clock; sole clock of the block.
- rstn_i  in  1  reset; asynchronous, active-low.
- sync_go_i  in  1  single-cycle request to run a sync sequence.
- sync_delay_i  in  5  local delay in ifclk cycles (0–31) between command acceptance and local phase restart; equals the offset programmed into the SURF.
- cmd_sync_o  out  1  SYNC command request to the command encoder; held until acknowledged.
- cmd_ack_i  in  1  command encoder accepted the SYNC (one cycle).
- surf_sync_i  in  1  returned SURF sync; one-cycle pulse every 16 cycles.
- phase_o  out  4  local phase counter.
- sync_o  out  1  high iff phase_o == 15.
- busy_o  out  1  sequence in progress (state ≠ IDLE).
- done_o  out  1  one-cycle pulse at the end of a successful sequence.
- latency_o  out  8  ifclk cycles from cmd_ack_i to the first returned surf_sync_i.
- timeout_o  out  1  sticky: no surf_sync_i within MEAS_TIMEOUT.
- phase_err_o  out  1  sticky: surf_sync_i arrived at a phase other than the locked one.

## Operation
- Phase counter: free-running 0→15, wraps to 0. It is loaded with 0 at the DELAY terminal; the load overrides the increment.
- The register for sync_o updates together with phase_o.
- FSM states are IDLE, ALIGN, ISSUE, DELAY, MEASURE, CHECK.
- IDLE:
  - sync_go_i → ALIGN.
  - sync_go_i also clears timeout_o, phase_err_o and the lock flag.
  - sync_go_i is ignored in all other states.
- ALIGN: wait until phase_o == 15, then → ISSUE.
- ISSUE:
  - cmd_sync_o = 1 until cmd_ack_i.
  - On ack: clear the delay and latency counters; → DELAY.
- DELAY:
  - The delay counter increments each cycle.
  - When the counter equals sync_delay_i, load phase to 0 on the next edge and → MEASURE.
  - The latency counter also runs during DELAY.
  - sync_delay_i is sampled only in DELAY; changing it mid-sequence takes effect immediately.
- MEASURE:
  - The latency counter increments each cycle and saturates at 255.
  - On surf_sync_i: latency_o ← count, lock_phase ← phase_o, → CHECK.
  - If the count reaches MEAS_TIMEOUT first: timeout_o ← 1, → IDLE, no done_o.
- CHECK:
  - The next surf_sync_i must arrive with phase_o == lock_phase. On a match: done_o, set lock flag, → IDLE.
  - On a mismatch: phase_err_o ← 1, → IDLE, no done_o.
  - If no pulse arrives within 17 cycles: timeout_o ← 1, → IDLE.
- Monitor: while the lock flag is set, any surf_sync_i with phase_o ≠ lock_phase sets phase_err_o. The lock flag stays set.
- A surf_sync_i in the same cycle as cmd_ack_i is stale and is ignored. Any surf_sync_i before MEASURE is ignored.
- latency_o holds its value until the next successful MEASURE capture.

## Timing
- Reset values while rstn_i is low: state IDLE; all outputs 0; phase_o = 0.
- Reset asserted mid-sequence aborts immediately. cmd_sync_o drops asynchronously.
- Counting after reset release: phase_o increments from the first clock edge.
- sync_go_i → ALIGN on the next edge.
- ISSUE is entered the edge after phase_o == 15 is observed. Entering ISSUE therefore coincides with phase_o == 0.
- Latency count: the latency counter reads 0 in the first cycle after the ack cycle.
- Local restart with sync_delay_i = D: phase_o == 0 in cycle ack+D+2.
- done_o arrives exactly 16 cycles after the MEASURE capture cycle plus one.
- All outputs are registered. There are no combinational paths from input to output except the asynchronous reset.

## Test plan
- Reset then idle: rstn_i low mid-count → all outputs 0. After release, sync_o pulses every 16 cycles at phase_o == 15.
- Nominal sequence:
  - Stimulus: sync_go_i at phase 3; ack 2 cycles after cmd_sync_o rises; sync_delay_i = 5; model returns surf_sync_i 40 cycles after ack, then every 16 cycles.
  - Required: ISSUE starts at phase 0; phase_o == 0 at ack+7; latency_o = 39; done_o once; no errors.
- Timeout: no surf_sync_i → timeout_o = 1 at ack+MEAS_TIMEOUT+1, busy_o drops, done_o stays 0. A new sync_go_i clears timeout_o.
- Phase slip after lock: delay one returned pulse by 1 cycle → phase_err_o = 1 on that pulse and remains set.
- Simultaneous and ignored events: sync_go_i while busy → no restart. surf_sync_i in the ack cycle → not captured. sync_delay_i = 0 and 31 → phase restart at ack+2 and ack+33.
- Reset mid-ISSUE: rstn_i low while cmd_sync_o = 1 → cmd_sync_o = 0 immediately, state IDLE after release.
